// File: rtl/stream_xbar_rsp_router.sv
// Response router for one crossbar output: forwards requests to the target and steers responses
// back to the issuing input via an in-order index FIFO. Optional: STREAM_XBAR_RSP_ROUTER_DROP_EN.
module stream_xbar_rsp_router #(
    parameter int unsigned NumInp   = 32'd2,
    parameter int unsigned MaxTxns  = 32'd4,
    parameter int unsigned ReqWidth = 32'd32,
    parameter int unsigned RspWidth = 32'd32,
    parameter int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1,
    parameter int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ReqWidth-1:0]        req_data_i,
    input  logic [IdxWidth-1:0]        req_idx_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    output logic [ReqWidth-1:0]        mst_req_data_o,
    output logic                       mst_req_valid_o,
    input  logic                       mst_req_ready_i,
    input  logic [RspWidth-1:0]        mst_rsp_data_i,
    input  logic                       mst_rsp_valid_i,
    output logic                       mst_rsp_ready_o,
    output logic [NumInp*RspWidth-1:0] rsp_data_o,
    output logic [NumInp-1:0]          rsp_valid_o,
    input  logic [NumInp-1:0]          rsp_ready_i,
    output logic [CntWidth-1:0]        outstanding_o,
    output logic                       err_o
);

    localparam int unsigned PtrWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

    logic [IdxWidth-1:0] fifo_q [MaxTxns];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic [IdxWidth-1:0] head;
    logic                full, empty, push, pop;

    assign full  = (count_q == CntWidth'(MaxTxns));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    assign mst_req_valid_o = req_valid_i & ~full;
    assign req_ready_o     = mst_req_ready_i & ~full;
    assign mst_req_data_o  = req_data_i;

    assign rsp_data_o    = {NumInp{mst_rsp_data_i}};
    assign outstanding_o = count_q;

    always_comb begin
        rsp_valid_o = '0;
        if (mst_rsp_valid_i && !empty) begin
            rsp_valid_o[head] = 1'b1;
        end
    end

`ifdef STREAM_XBAR_RSP_ROUTER_DROP_EN
    logic err_q;

    // An unexpected response is sunk here so it cannot stall the target.
    assign mst_rsp_ready_o = empty ? 1'b1 : rsp_ready_i[head];
    assign err_o           = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (mst_rsp_valid_i && empty) begin
            err_q <= 1'b1;
        end
    end
`else
    assign mst_rsp_ready_o = ~empty & rsp_ready_i[head];
    assign err_o           = 1'b0;
`endif

    assign push = req_valid_i & req_ready_o;
    assign pop  = mst_rsp_valid_i & mst_rsp_ready_o & ~empty;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= req_idx_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrWidth'(MaxTxns - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrWidth'(MaxTxns - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_xbar_rsp_router.sv
// Directed bench for stream_xbar_rsp_router: a 4-deep instance for routing/full/back-pressure
// and a 3-deep instance for non-power-of-2 pointer wrap.
module tb_stream_xbar_rsp_router;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] req_data, mst_req_data, mst_rsp_data;
    logic        req_idx, req_valid, req_ready, mst_req_valid, mst_req_ready;
    logic        mst_rsp_valid, mst_rsp_ready, err;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [2:0]  outstanding;

    logic [31:0] req_data3, mst_req_data3, mst_rsp_data3;
    logic        req_idx3, req_valid3, req_ready3, mst_req_valid3, mst_req_ready3;
    logic        mst_rsp_valid3, mst_rsp_ready3, err3;
    logic [63:0] rsp_data3;
    logic [1:0]  rsp_valid3, rsp_ready3;
    logic [1:0]  outstanding3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_xbar_rsp_router #(.NumInp(2), .MaxTxns(4), .ReqWidth(32), .RspWidth(32)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_data_i(req_data), .req_idx_i(req_idx), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .mst_req_data_o(mst_req_data), .mst_req_valid_o(mst_req_valid), .mst_req_ready_i(mst_req_ready),
        .mst_rsp_data_i(mst_rsp_data), .mst_rsp_valid_i(mst_rsp_valid), .mst_rsp_ready_o(mst_rsp_ready),
        .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .outstanding_o(outstanding), .err_o(err)
    );

    stream_xbar_rsp_router #(.NumInp(2), .MaxTxns(3), .ReqWidth(32), .RspWidth(32)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .req_data_i(req_data3), .req_idx_i(req_idx3), .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .mst_req_data_o(mst_req_data3), .mst_req_valid_o(mst_req_valid3), .mst_req_ready_i(mst_req_ready3),
        .mst_rsp_data_i(mst_rsp_data3), .mst_rsp_valid_i(mst_rsp_valid3), .mst_rsp_ready_o(mst_rsp_ready3),
        .rsp_data_o(rsp_data3), .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
        .outstanding_o(outstanding3), .err_o(err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] drain_vld [3];
        drain_vld[0] = 2'b10; drain_vld[1] = 2'b10; drain_vld[2] = 2'b01;

        rst = 1'b1;
        req_data = '0; req_idx = 1'b0; req_valid = 1'b0; mst_req_ready = 1'b1;
        mst_rsp_data = '0; mst_rsp_valid = 1'b0; rsp_ready = 2'b11;
        req_data3 = '0; req_idx3 = 1'b0; req_valid3 = 1'b0; mst_req_ready3 = 1'b1;
        mst_rsp_data3 = '0; mst_rsp_valid3 = 1'b0; rsp_ready3 = 2'b11;
        step(); step();
        rst = 1'b0;
        #1;

        // Idle after reset
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mst_rsp_ready", mst_rsp_ready, 0);
        chk("rst_mst_req_valid", mst_req_valid, 0);
        chk("rst_err", err, 0);
        chk("idle_req_ready_hi", req_ready, 1);
        mst_req_ready = 1'b0; #1;
        chk("idle_req_ready_lo", req_ready, 0);
        mst_req_ready = 1'b1;
        chk("rst_outstanding3", outstanding3, 0);

        // Push idx 1, 0, 1 then route responses A, B, C
        req_valid = 1'b1;
        req_idx = 1'b1; req_data = 32'h0000_0101; #1;
        chk("push0_mst_req_valid", mst_req_valid, 1);
        chk("push0_mst_req_data", mst_req_data, 32'h0000_0101);
        chk("push0_req_ready", req_ready, 1);
        step();
        req_idx = 1'b0; req_data = 32'h0000_0102; #1;
        chk("push1_mst_req_data", mst_req_data, 32'h0000_0102);
        chk("push1_outstanding", outstanding, 1);
        step();
        req_idx = 1'b1; req_data = 32'h0000_0103;
        step();
        req_valid = 1'b0; #1;
        chk("push_outstanding3", outstanding, 3);

        mst_rsp_valid = 1'b1; mst_rsp_data = 32'hA; #1;
        chk("rspA_valid", rsp_valid, 2'b10);
        chk("rspA_data", rsp_data, {2{32'hA}});
        chk("rspA_mst_ready", mst_rsp_ready, 1);
        step();
        chk("rspA_outstanding", outstanding, 2);
        mst_rsp_data = 32'hB; #1;
        chk("rspB_valid", rsp_valid, 2'b01);
        chk("rspB_data", rsp_data, {2{32'hB}});
        step();
        chk("rspB_outstanding", outstanding, 1);
        mst_rsp_data = 32'hC; #1;
        chk("rspC_valid", rsp_valid, 2'b10);
        step();
        chk("rspC_outstanding", outstanding, 0);
        mst_rsp_valid = 1'b0; #1;
        chk("empty_rsp_valid", rsp_valid, 0);

        // Fill to MaxTxns=4 with idx 0,0,1,1
        req_valid = 1'b1;
        req_idx = 1'b0; step();
        req_idx = 1'b0; step();
        req_idx = 1'b1; step();
        req_idx = 1'b1; step();
        req_idx = 1'b0; #1;
        chk("full_outstanding", outstanding, 4);
        chk("full_req_ready", req_ready, 0);
        chk("full_mst_req_valid", mst_req_valid, 0);
        mst_rsp_valid = 1'b1; mst_rsp_data = 32'hD; #1;
        chk("full_pop_rsp_valid", rsp_valid, 2'b01);
        chk("full_pop_mst_ready", mst_rsp_ready, 1);
        chk("full_pop_req_ready", req_ready, 0);
        step();
        mst_rsp_valid = 1'b0; #1;
        chk("after_pop_outstanding", outstanding, 3);
        chk("after_pop_req_ready", req_ready, 1);
        step();
        req_valid = 1'b0; #1;
        chk("refill_outstanding", outstanding, 4);

        // Head idx 0, only non-head port ready
        rsp_ready = 2'b10; mst_rsp_valid = 1'b1; mst_rsp_data = 32'h55; #1;
        chk("bp_rsp_valid", rsp_valid, 2'b01);
        chk("bp_mst_ready", mst_rsp_ready, 0);
        step();
        chk("bp_hold_rsp_valid", rsp_valid, 2'b01);
        chk("bp_hold_data", rsp_data, {2{32'h55}});
        chk("bp_hold_outstanding", outstanding, 4);
        rsp_ready = 2'b11; #1;
        chk("bp_release_mst_ready", mst_rsp_ready, 1);
        step();
        chk("bp_release_outstanding", outstanding, 3);

        for (int unsigned k = 0; k < 3; k++) begin
            mst_rsp_data = 32'h200 + k; #1;
            chk("drain_rsp_valid", rsp_valid, drain_vld[k]);
            step();
            chk("drain_outstanding", outstanding, 2 - k);
        end
        mst_rsp_valid = 1'b0;

        // Wrap on the 3-deep instance: steady state of two outstanding
        req_valid3 = 1'b1;
        req_idx3 = 1'b0; step();
        req_idx3 = 1'b1; step();
        mst_rsp_valid3 = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            req_idx3 = i[0];
            mst_rsp_data3 = 32'h300 + i; #1;
            chk("wrap_rsp_valid", rsp_valid3, i[0] ? 2'b10 : 2'b01);
            chk("wrap_rsp_data", rsp_data3, {2{32'h300 + i}});
            step();
            chk("wrap_outstanding", outstanding3, 2);
        end
        req_valid3 = 1'b0; #1;
        chk("wrap_drain0_valid", rsp_valid3, 2'b01);
        step();
        chk("wrap_drain1_valid", rsp_valid3, 2'b10);
        step();
        mst_rsp_valid3 = 1'b0; #1;
        chk("wrap_final_outstanding", outstanding3, 0);

        // Unexpected response with empty FIFO
        mst_rsp_valid = 1'b1; mst_rsp_data = 32'hEE; #1;
        chk("unexp_rsp_valid", rsp_valid, 0);
        chk("unexp_err_same_cycle", err, 0);
`ifdef STREAM_XBAR_RSP_ROUTER_DROP_EN
        chk("unexp_mst_ready", mst_rsp_ready, 1);
        step();
        mst_rsp_valid = 1'b0; #1;
        chk("unexp_err_set", err, 1);
        step();
        chk("unexp_err_sticky", err, 1);
        chk("unexp_outstanding", outstanding, 0);
`else
        chk("unexp_mst_ready", mst_rsp_ready, 0);
        step();
        chk("unexp_err", err, 0);
        chk("unexp_stall_valid", rsp_valid, 0);
        mst_rsp_valid = 1'b0;
`endif

        // Reset mid-operation discards tracked entries
        req_valid = 1'b1; req_idx = 1'b1; step(); step();
        req_valid = 1'b0; #1;
        chk("pre_rst_outstanding", outstanding, 2);
        rst = 1'b1; step();
        rst = 1'b0; #1;
        chk("midrst_outstanding", outstanding, 0);
        chk("midrst_err", err, 0);
        mst_rsp_valid = 1'b1; #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
`ifdef STREAM_XBAR_RSP_ROUTER_DROP_EN
        chk("midrst_mst_ready", mst_rsp_ready, 1);
`else
        chk("midrst_mst_ready", mst_rsp_ready, 0);
`endif
        mst_rsp_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
